// File: rtl/i2c_codec_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_codec_responder_if
// Purpose  : SCL/SDA bus bundle between an I2C master and the codec responder.
// Revision : 1.0
// ============================================================================
interface i2c_codec_responder_if;
    logic i_scl;
    logic i_sda;
    logic o_sda_oen;

    modport master (output i_scl, output i_sda, input o_sda_oen);
    modport slave  (input i_scl, input i_sda, output o_sda_oen);
endinterface
`default_nettype wire

// File: rtl/i2c_codec_responder.sv
`default_nettype none
// ============================================================================
// Module   : i2c_codec_responder
// Purpose  : WM8731-style write-only I2C target with a 16 x 9-bit register
//            file. Optional SCL/SDA majority glitch filter: I2C_GLITCH_FILTER_EN.
// Revision : 1.0
// ============================================================================
module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         CNT_W    = 8
) (
    input  wire logic               i_clk,
    input  wire logic               i_rst,
    i2c_codec_responder_if.slave    bus,
    output logic                    o_reg_wr,
    output logic [6:0]              o_reg_addr,
    output logic [8:0]              o_reg_data,
    input  wire logic [3:0]         i_rd_addr,
    output logic [8:0]              o_rd_data,
    output logic                    o_frame_err,
    output logic [CNT_W-1:0]        o_write_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        ACK_A  = 3'd2,
        BYTE1  = 3'd3,
        ACK_1  = 3'd4,
        BYTE2  = 3'd5,
        ACK_2  = 3'd6,
        IGNORE = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       ADDR_WR = {DEV_ADDR, 1'b0};

    // Synchronizers reset to the idle bus level so reset release is not an edge.
    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_w;
    logic       sda_w;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], bus.i_scl};
            sda_sync_q <= {sda_sync_q[0], bus.i_sda};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_tap_q;
    logic [1:0] sda_tap_q;
    logic       scl_flt_q;
    logic       sda_flt_q;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_tap_q <= 2'b11;
            sda_tap_q <= 2'b11;
            scl_flt_q <= 1'b1;
            sda_flt_q <= 1'b1;
        end else begin
            scl_tap_q <= {scl_tap_q[0], scl_sync_q[1]};
            sda_tap_q <= {sda_tap_q[0], sda_sync_q[1]};
            scl_flt_q <= maj3(scl_sync_q[1], scl_tap_q[0], scl_tap_q[1]);
            sda_flt_q <= maj3(sda_sync_q[1], sda_tap_q[0], sda_tap_q[1]);
        end
    end

    assign scl_w = scl_flt_q;
    assign sda_w = sda_flt_q;
`else
    assign scl_w = scl_sync_q[1];
    assign sda_w = sda_sync_q[1];
`endif

    logic scl_prev_q;
    logic sda_prev_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_w;
            sda_prev_q <= sda_w;
        end
    end

    logic scl_rise;
    logic scl_fall;
    logic bus_start;
    logic bus_stop;

    // SCL must be high on both sides of the SDA edge to count as START/STOP.
    assign scl_rise  =  scl_w & ~scl_prev_q;
    assign scl_fall  = ~scl_w &  scl_prev_q;
    assign bus_start =  scl_w &  scl_prev_q &  sda_prev_q & ~sda_w;
    assign bus_stop  =  scl_w &  scl_prev_q & ~sda_prev_q &  sda_w;

    state_t           state_q;
    logic [2:0]       bit_cnt_q;
    logic [6:0]       shift_q;
    logic [7:0]       byte1_q;
    logic             ack_drive_q;
    logic             sda_oen_q;
    logic             reg_wr_q;
    logic [6:0]       reg_addr_q;
    logic [8:0]       reg_data_q;
    logic             frame_err_q;
    logic [CNT_W-1:0] wr_cnt_q;
    logic [8:0]       regfile_q [16];

    logic [7:0]       byte_d;
    logic [6:0]       reg_d;
    logic [8:0]       data_d;
    logic             last_bit;
    logic             in_frame;

    assign byte_d   = {shift_q, sda_w};
    assign reg_d    = byte1_q[7:1];
    assign data_d   = {byte1_q[0], byte_d};
    assign last_bit = (bit_cnt_q == 3'd7);
    // Before the commit, losing the bus means a half-written register.
    assign in_frame = (state_q == ADDR)  || (state_q == ACK_A) ||
                      (state_q == BYTE1) || (state_q == ACK_1) ||
                      (state_q == BYTE2);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            byte1_q     <= 8'd0;
            ack_drive_q <= 1'b0;
            sda_oen_q   <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_addr_q  <= 7'd0;
            reg_data_q  <= 9'd0;
            frame_err_q <= 1'b0;
            wr_cnt_q    <= '0;
            for (int i = 0; i < 16; i++) begin
                regfile_q[i] <= 9'd0;
            end
        end else begin
            reg_wr_q    <= 1'b0;
            frame_err_q <= 1'b0;

            if (bus_start || bus_stop) begin
                sda_oen_q   <= 1'b0;
                ack_drive_q <= 1'b0;
                bit_cnt_q   <= 3'd0;
                if (in_frame) begin
                    frame_err_q <= 1'b1;
                end
                state_q <= bus_start ? ADDR : IDLE;
            end else begin
                case (state_q)
                    ADDR, BYTE1, BYTE2: begin
                        if (scl_rise) begin
                            shift_q   <= byte_d[6:0];
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (last_bit) begin
                                if (state_q == ADDR) begin
                                    state_q <= (byte_d == ADDR_WR) ? ACK_A : IGNORE;
                                end else if (state_q == BYTE1) begin
                                    byte1_q <= byte_d;
                                    state_q <= ACK_1;
                                end else begin
                                    state_q    <= ACK_2;
                                    reg_wr_q   <= 1'b1;
                                    reg_addr_q <= reg_d;
                                    reg_data_q <= data_d;
                                    if (wr_cnt_q != {CNT_W{1'b1}}) begin
                                        wr_cnt_q <= wr_cnt_q + CNT_ONE;
                                    end
                                    // Register 0x0F is the codec reset: wipe, then store.
                                    if (reg_d == 7'h0F) begin
                                        for (int i = 0; i < 16; i++) begin
                                            regfile_q[i] <= 9'd0;
                                        end
                                        regfile_q[15] <= data_d;
                                    end else if (reg_d[6:4] == 3'b000) begin
                                        regfile_q[reg_d[3:0]] <= data_d;
                                    end else begin
                                        frame_err_q <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    ACK_A, ACK_1, ACK_2: begin
                        if (scl_fall) begin
                            if (!ack_drive_q) begin
                                ack_drive_q <= 1'b1;
                                sda_oen_q   <= 1'b1;
                            end else begin
                                ack_drive_q <= 1'b0;
                                sda_oen_q   <= 1'b0;
                                bit_cnt_q   <= 3'd0;
                                case (state_q)
                                    ACK_A:   state_q <= BYTE1;
                                    ACK_1:   state_q <= BYTE2;
                                    default: state_q <= IGNORE;
                                endcase
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.o_sda_oen = sda_oen_q;
    assign o_reg_wr      = reg_wr_q;
    assign o_reg_addr    = reg_addr_q;
    assign o_reg_data    = reg_data_q;
    assign o_rd_data     = regfile_q[i_rd_addr];
    assign o_frame_err   = frame_err_q;
    assign o_write_count = wr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_codec_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_codec_responder
// Purpose  : Self-checking bench: frame table plus hand-built corner sequences.
// Revision : 1.0
// ============================================================================
module tb_i2c_codec_responder;

    localparam int Q = 4;

    typedef struct packed {
        logic       wr;
        logic [6:0] addr;
        logic [8:0] data;
        logic       err;
    } ev_t;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [2:0] ack;
        logic       has_ev;
        ev_t        ev;
        logic [3:0] rd_idx;
        logic [8:0] rd_exp;
        logic [7:0] cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [3:0] rd_idx = 4'd0;
    logic       o_reg_wr;
    logic [6:0] o_reg_addr;
    logic [8:0] o_reg_data;
    logic [8:0] o_rd_data;
    logic       o_frame_err;
    logic [7:0] o_write_count;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  oen_cnt = 0;
    ev_t exp_q[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    i2c_codec_responder_if bus();
    assign bus.i_scl = m_scl;
    assign bus.i_sda = m_sda & ~bus.o_sda_oen;

    i2c_codec_responder #(.DEV_ADDR(7'h1A), .CNT_W(8)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .bus           (bus),
        .o_reg_wr      (o_reg_wr),
        .o_reg_addr    (o_reg_addr),
        .o_reg_data    (o_reg_data),
        .i_rd_addr     (rd_idx),
        .o_rd_data     (o_rd_data),
        .o_frame_err   (o_frame_err),
        .o_write_count (o_write_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) if (bus.o_sda_oen === 1'b1) oen_cnt++;

    // Scoreboard: every write/error pulse must match the oldest expected event.
    always @(negedge clk) begin
        ev_t got;
        if (!rst && (o_reg_wr || o_frame_err)) begin
            got = {o_reg_wr, o_reg_addr, o_reg_data, o_frame_err};
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got %0h expected none", got);
            end else begin
                check("event", 32'(got), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(2*Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    wait_clk(Q);
        m_scl = 1'b1; wait_clk(2*Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        ack = bus.o_sda_oen;
        wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    function automatic ev_t mk_ev(input logic wr, input logic [6:0] a,
                                  input logic [8:0] d, input logic err);
        ev_t e;
        e.wr = wr; e.addr = a; e.data = d; e.err = err;
        return e;
    endfunction

    function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input logic [2:0] ack, input logic has_ev, input logic [6:0] a,
                                input logic [8:0] d, input logic err, input logic [3:0] idx,
                                input logic [8:0] rd, input logic [7:0] cnt);
        vec_t v;
        v.b0 = b0; v.b1 = b1; v.b2 = b2; v.ack = ack; v.has_ev = has_ev;
        v.ev = mk_ev(1'b1, a, d, err);
        v.rd_idx = idx; v.rd_exp = rd; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        logic       a0, a1, a2, a3;
        int         oen_before;

        vecs[0]  = mk(8'h34, 8'h08, 8'h12, 3'b111, 1'b1, 7'h04, 9'h012, 1'b0, 4'd4,  9'h012, 8'd1);
        vecs[1]  = mk(8'h34, 8'h0D, 8'h00, 3'b111, 1'b1, 7'h06, 9'h100, 1'b0, 4'd6,  9'h100, 8'd2);
        vecs[2]  = mk(8'h34, 8'h1E, 8'h00, 3'b111, 1'b1, 7'h0F, 9'h000, 1'b0, 4'd6,  9'h000, 8'd3);
        vecs[3]  = mk(8'h34, 8'h05, 8'h55, 3'b111, 1'b1, 7'h02, 9'h155, 1'b0, 4'd2,  9'h155, 8'd4);
        vecs[4]  = mk(8'h34, 8'h1E, 8'hAA, 3'b111, 1'b1, 7'h0F, 9'h0AA, 1'b0, 4'd2,  9'h000, 8'd5);
        vecs[5]  = mk(8'h34, 8'h1F, 8'hFF, 3'b111, 1'b1, 7'h0F, 9'h1FF, 1'b0, 4'd15, 9'h1FF, 8'd6);
        vecs[6]  = mk(8'h36, 8'h08, 8'h12, 3'b000, 1'b0, 7'h00, 9'h000, 1'b0, 4'd15, 9'h1FF, 8'd6);
        vecs[7]  = mk(8'h35, 8'h08, 8'h12, 3'b000, 1'b0, 7'h00, 9'h000, 1'b0, 4'd4,  9'h000, 8'd6);
        vecs[8]  = mk(8'h34, 8'h40, 8'h77, 3'b111, 1'b1, 7'h20, 9'h077, 1'b1, 4'd0,  9'h000, 8'd7);
        vecs[9]  = mk(8'h34, 8'hFE, 8'h01, 3'b111, 1'b1, 7'h7F, 9'h001, 1'b1, 4'd15, 9'h1FF, 8'd8);
        vecs[10] = mk(8'h34, 8'h20, 8'h3C, 3'b111, 1'b1, 7'h10, 9'h03C, 1'b1, 4'd0,  9'h000, 8'd9);
        vecs[11] = mk(8'h34, 8'h1C, 8'hC3, 3'b111, 1'b1, 7'h0E, 9'h0C3, 1'b0, 4'd14, 9'h0C3, 8'd10);

        // Reset state
        wait_clk(5);
        rst = 1'b0;
        wait_clk(5);
        check("rst_oen",   32'(bus.o_sda_oen), 32'd0);
        check("rst_wr",    32'(o_reg_wr),      32'd0);
        check("rst_err",   32'(o_frame_err),   32'd0);
        check("rst_addr",  32'(o_reg_addr),    32'd0);
        check("rst_data",  32'(o_reg_data),    32'd0);
        check("rst_count", 32'(o_write_count), 32'd0);
        check("rst_rd0",   32'(o_rd_data),     32'd0);

        // One-cycle SDA low pulse with SCL high while idle
`ifndef I2C_GLITCH_FILTER_EN
        exp_q.push_back(mk_ev(1'b0, 7'h00, 9'h000, 1'b1));
`endif
        @(negedge clk); m_sda = 1'b0;
        @(negedge clk); m_sda = 1'b1;
        wait_clk(12);

        // Table of complete frames
        for (int k = 0; k < 12; k++) begin
            if (vecs[k].has_ev) exp_q.push_back(vecs[k].ev);
            oen_before = oen_cnt;
            i2c_start();
            send_byte(vecs[k].b0, a0);
            send_byte(vecs[k].b1, a1);
            send_byte(vecs[k].b2, a2);
            i2c_stop();
            wait_clk(8);
            check($sformatf("v%0d_ack", k), 32'({a0, a1, a2}), 32'(vecs[k].ack));
            if (vecs[k].ack == 3'b000)
                check($sformatf("v%0d_noack_oen", k), 32'(oen_cnt - oen_before), 32'd0);
            rd_idx = vecs[k].rd_idx;
            #1;
            check($sformatf("v%0d_rd", k),    32'(o_rd_data),     32'(vecs[k].rd_exp));
            check($sformatf("v%0d_count", k), 32'(o_write_count), 32'(vecs[k].cnt));
        end

        // Fourth byte after the committed frame is not acknowledged
        exp_q.push_back(mk_ev(1'b1, 7'h08, 9'h001, 1'b0));
        i2c_start();
        send_byte(8'h34, a0);
        send_byte(8'h10, a1);
        send_byte(8'h01, a2);
        send_byte(8'h99, a3);
        i2c_stop();
        wait_clk(8);
        check("b4_ack", 32'({a0, a1, a2, a3}), 32'b1110);
        rd_idx = 4'd8; #1;
        check("b4_rd8", 32'(o_rd_data), 32'h001);

        // STOP after four bits of byte 2 aborts without touching the register
        exp_q.push_back(mk_ev(1'b1, 7'h04, 9'h012, 1'b0));
        i2c_start();
        send_byte(8'h34, a0); send_byte(8'h08, a1); send_byte(8'h12, a2);
        i2c_stop();
        wait_clk(8);
        exp_q.push_back(mk_ev(1'b0, 7'h04, 9'h012, 1'b1));
        i2c_start();
        send_byte(8'h34, a0); send_byte(8'h09, a1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        wait_clk(8);
        rd_idx = 4'd4; #1;
        check("abort_rd4",   32'(o_rd_data),     32'h012);
        check("abort_count", 32'(o_write_count), 32'd12);
        exp_q.push_back(mk_ev(1'b1, 7'h04, 9'h134, 1'b0));
        i2c_start();
        send_byte(8'h34, a0); send_byte(8'h09, a1); send_byte(8'h34, a2);
        i2c_stop();
        wait_clk(8);
        check("after_abort_rd4", 32'(o_rd_data), 32'h134);

        // Repeated START inside byte 2 aborts, then the new frame commits
        exp_q.push_back(mk_ev(1'b0, 7'h04, 9'h134, 1'b1));
        exp_q.push_back(mk_ev(1'b1, 7'h05, 9'h005, 1'b0));
        i2c_start();
        send_byte(8'h34, a0); send_byte(8'h0A, a1);
        i2c_start();
        send_byte(8'h34, a0); send_byte(8'h0A, a1); send_byte(8'h05, a2);
        i2c_stop();
        wait_clk(8);
        check("rstart_ack", 32'({a0, a1, a2}), 32'b111);
        rd_idx = 4'd5; #1;
        check("rstart_rd5",   32'(o_rd_data),     32'h005);
        check("rstart_count", 32'(o_write_count), 32'd14);

        // Reset asserted while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(logic'((8'h34 >> i) & 1));
        check("pre_reset_ack", 32'(bus.o_sda_oen), 32'd1);
        rst = 1'b1;
        #2;
        check("mid_reset_oen",   32'(bus.o_sda_oen), 32'd0);
        check("mid_reset_count", 32'(o_write_count), 32'd0);
        rd_idx = 4'd15; #1;
        check("mid_reset_rd15",  32'(o_rd_data),     32'd0);
        m_scl = 1'b1; m_sda = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(8);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
